// File: rtl/prco_pipe_seq_pkg.sv
// -----------------------------------------------------------------------------
// prco_pipe_seq_pkg
// Shared definitions for the prco stage sequencer: FSM state encoding, the
// stage index type and named stage indices, and a small state helper.
// No ports (package).
// -----------------------------------------------------------------------------
package prco_pipe_seq_pkg;

  // Sequencer states. ERROR is terminal until reset.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RETIRE,
    ST_HALTED,
    ST_ERROR
  } state_t;

  // Up to 8 stages, so a stage index always fits in 3 bits.
  localparam int STAGE_IDX_W = 3;
  localparam int MAX_STAGES  = 8;

  typedef logic [STAGE_IDX_W-1:0] stage_idx_t;

  // Named stages of the classic five-stage prco core.
  localparam stage_idx_t STAGE_FETCH = 3'd0;
  localparam stage_idx_t STAGE_MEM   = 3'd1;
  localparam stage_idx_t STAGE_DEC   = 3'd2;
  localparam stage_idx_t STAGE_REG   = 3'd3;
  localparam stage_idx_t STAGE_ALU   = 3'd4;

  // An instruction is in flight in every state except IDLE, HALTED and ERROR.
  function automatic logic state_is_busy(input state_t s);
    return (s == ST_ISSUE) || (s == ST_WAIT) || (s == ST_RETIRE);
  endfunction

endpackage

// File: rtl/prco_pipe_seq_if.sv
// -----------------------------------------------------------------------------
// prco_pipe_seq_if
// Stage bus between the sequencer and the pipeline stages.
//   q_stage_ce      : one-hot, one-cycle start pulse per stage (sequencer out)
//   i_stage_done    : per-stage completion strobe (stages out)
//   i_skip_mask     : stages to bypass for this instruction, sampled with done
//   i_branch_taken  : redirect the PC when the instruction retires
//   i_branch_target : redirect address
// Modports: master = sequencer side, slave = stage side.
// -----------------------------------------------------------------------------
interface prco_pipe_seq_if #(
  parameter int NSTAGES = 5,
  parameter int PC_W    = 16
);

  logic [NSTAGES-1:0] q_stage_ce;
  logic [NSTAGES-1:0] i_stage_done;
  logic [NSTAGES-1:0] i_skip_mask;
  logic               i_branch_taken;
  logic [PC_W-1:0]    i_branch_target;

  modport master (
    output q_stage_ce,
    input  i_stage_done,
    input  i_skip_mask,
    input  i_branch_taken,
    input  i_branch_target
  );

  modport slave (
    input  q_stage_ce,
    output i_stage_done,
    output i_skip_mask,
    output i_branch_taken,
    output i_branch_target
  );

endinterface

// File: rtl/prco_pipe_seq_next_stage.sv
// -----------------------------------------------------------------------------
// prco_next_stage
// Combinational priority search: finds the lowest stage index strictly above
// cur_stage whose bit in skip_mask is clear.
//   cur_stage  : stage that just completed
//   skip_mask  : stages to bypass (accumulated skip register | live mask)
//   found      : a later stage exists that must still run
//   next_stage : index of that stage (cur_stage when none found)
// -----------------------------------------------------------------------------
module prco_next_stage
  import prco_pipe_seq_pkg::*;
#(
  parameter int NSTAGES = 5
) (
  input  stage_idx_t         cur_stage,
  input  logic [NSTAGES-1:0] skip_mask,
  output logic               found,
  output stage_idx_t         next_stage
);

  // Scanning from the top down lets the lowest qualifying index win last.
  always_comb begin
    found      = 1'b0;
    next_stage = cur_stage;
    for (int j = NSTAGES - 1; j >= 0; j--) begin
      if ((j > int'(cur_stage)) && !skip_mask[j]) begin
        found      = 1'b1;
        next_stage = stage_idx_t'(j);
      end
    end
  end

endmodule

// File: rtl/prco_pipe_seq.sv
// -----------------------------------------------------------------------------
// prco_pipe_seq
// Stage sequencer for the prco core. Walks a single instruction token through
// NSTAGES stages: each stage gets a one-cycle start pulse and the sequencer
// waits for its done. Supports per-instruction stage skipping, branch redirect
// at retire, halt/resume at instruction boundaries, a per-stage watchdog and a
// retired-instruction counter. All outputs are registered.
//   i_clk, i_reset : clock, asynchronous active-high reset
//   i_en           : run enable, gates only the start of a new instruction
//   i_halt         : halt request, honoured at instruction boundary
//   bus            : stage bus (ce out; done/skip/branch in)
//   q_pc           : address of the instruction in flight
//   q_busy         : instruction in flight
//   q_halted       : in HALTED
//   q_err          : sticky watchdog error
//   q_err_stage    : stage that timed out
//   q_retired      : retired-instruction count (wraps)
// -----------------------------------------------------------------------------
module prco_pipe_seq
  import prco_pipe_seq_pkg::*;
#(
  parameter int              NSTAGES  = 5,
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              TIMEOUT  = 255,
  parameter int              CNT_W    = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_en,
  input  logic                 i_halt,
  prco_pipe_seq_if.master      bus,
  output logic [PC_W-1:0]      q_pc,
  output logic                 q_busy,
  output logic                 q_halted,
  output logic                 q_err,
  output logic [2:0]           q_err_stage,
  output logic [CNT_W-1:0]     q_retired
);

  // Watchdog counts 0..TIMEOUT-1; a zero TIMEOUT disables expiry entirely.
  localparam bit WD_ON   = (TIMEOUT > 0);
  localparam int WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int WD_LAST = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;

  state_t             state;
  state_t             next_state;
  stage_idx_t         cur_stage;
  stage_idx_t         next_k;
  logic [NSTAGES-1:0] skip_reg;
  logic [NSTAGES-1:0] search_mask;
  logic [NSTAGES-1:0] above_cur;
  logic [NSTAGES-1:0] ce_next;
  logic [WD_W-1:0]    wd_cnt;
  logic               wd_expired;
  logic               done_cur;
  logic               next_found;
  stage_idx_t         next_idx;

  // Only the done strobe of the stage we are waiting on matters; the other
  // bits are ignored. above_cur limits skip accumulation to later stages.
  always_comb begin
    done_cur  = 1'b0;
    above_cur = '0;
    for (int j = 0; j < NSTAGES; j++) begin
      if (j == int'(cur_stage)) begin
        done_cur = bus.i_stage_done[j];
      end
      if (j > int'(cur_stage)) begin
        above_cur[j] = 1'b1;
      end
    end
  end

  assign search_mask = skip_reg | bus.i_skip_mask;
  assign wd_expired  = WD_ON && (wd_cnt == WD_W'(WD_LAST));

  prco_next_stage #(
    .NSTAGES (NSTAGES)
  ) u_next_stage (
    .cur_stage  (cur_stage),
    .skip_mask  (search_mask),
    .found      (next_found),
    .next_stage (next_idx)
  );

  // Next-state logic. A done arriving on the last allowed WAIT cycle still
  // wins over the watchdog.
  always_comb begin
    next_state = state;
    next_k     = cur_stage;
    case (state)
      ST_IDLE: begin
        if (i_halt) begin
          next_state = ST_HALTED;
        end else if (i_en) begin
          next_state = ST_ISSUE;
          next_k     = STAGE_FETCH;
        end
      end
      ST_ISSUE: begin
        next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (done_cur) begin
          if (next_found) begin
            next_state = ST_ISSUE;
            next_k     = next_idx;
          end else begin
            next_state = ST_RETIRE;
          end
        end else if (wd_expired) begin
          next_state = ST_ERROR;
        end
      end
      ST_RETIRE: begin
        if (i_halt) begin
          next_state = ST_HALTED;
        end else if (i_en) begin
          next_state = ST_ISSUE;
          next_k     = STAGE_FETCH;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_HALTED: begin
        if (!i_halt) begin
          next_state = ST_IDLE;
        end
      end
      ST_ERROR: begin
        next_state = ST_ERROR;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // The start pulse is computed from the next state so the registered ce is
  // high exactly during the ISSUE cycle.
  always_comb begin
    ce_next = '0;
    if (next_state == ST_ISSUE) begin
      for (int j = 0; j < NSTAGES; j++) begin
        if (j == int'(next_k)) begin
          ce_next[j] = 1'b1;
        end
      end
    end
  end

  // State register and current stage index.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= ST_IDLE;
      cur_stage <= STAGE_FETCH;
    end else begin
      state     <= next_state;
      cur_stage <= next_k;
    end
  end

  // Per-instruction bookkeeping: skip accumulation and the stage watchdog.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      skip_reg <= '0;
      wd_cnt   <= '0;
    end else begin
      if (state == ST_RETIRE) begin
        skip_reg <= '0;
      end else if ((state == ST_WAIT) && done_cur) begin
        skip_reg <= skip_reg | (bus.i_skip_mask & above_cur);
      end

      if (state == ST_ISSUE) begin
        wd_cnt <= '0;
      end else if (state == ST_WAIT) begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end
    end
  end

  // Registered status and stage-start outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      bus.q_stage_ce <= '0;
      q_busy         <= 1'b0;
      q_halted       <= 1'b0;
      q_err          <= 1'b0;
      q_err_stage    <= '0;
    end else begin
      bus.q_stage_ce <= ce_next;
      q_busy         <= state_is_busy(next_state);
      q_halted       <= (next_state == ST_HALTED);
      if ((state == ST_WAIT) && (next_state == ST_ERROR)) begin
        q_err       <= 1'b1;
        q_err_stage <= cur_stage;
      end
    end
  end

  // PC and retire counter only move in the RETIRE cycle, which also keeps
  // them frozen in HALTED and ERROR.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      q_pc      <= RESET_PC;
      q_retired <= '0;
    end else if (state == ST_RETIRE) begin
      q_pc      <= bus.i_branch_taken ? bus.i_branch_target : (q_pc + PC_W'(1));
      q_retired <= q_retired + CNT_W'(1);
    end
  end

endmodule
